regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Write-back scheduler for the 15-entry general register file plus R15. It shares the register file's single write port (RegWrite/A3/WD3) between two requesters: the ALU result path and the memory load path. Each requester has its own small FIFO, and the arbiter grants the port round-robin. Writes targeting R15 are diverted to a PC-write output, because the register file never stores R15. It also exports a pending-write scoreboard so decode can stall on read-after-write hazards.

Parameters:
DEPTH, 2, entries per requester FIFO; power of two, at least 2
DATA_W, 32, write data width

Ports:
clk  input  1  clock
Reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous discard of all queued and staged writes
alu_valid  input  1  ALU write request
alu_ready  output  1  ALU FIFO can accept
alu_addr  input  4  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load write request
mem_ready  output  1  load FIFO can accept
mem_addr  input  4  load destination register
mem_data  input  DATA_W  load data
RegWrite  output  1  register file write enable (registered)
A3  output  4  register file write address (registered)
WD3  output  DATA_W  register file write data (registered)
PCWrite  output  1  R15 write strobe (registered)
PCData  output  DATA_W  R15 write value (registered)
pending  output  16  bit r set while a write to register r is queued or staged

Behaviour:
- Reset (clk is clk; Reset is asynchronous, active-low):
  - Clears both FIFOs (pointers and counts).
  - RegWrite=0, A3=0, WD3=0, PCWrite=0, PCData=0, pending=0.
  - Round-robin priority set to ALU.
  - Reset mid-operation discards all queued writes; nothing is emitted afterwards.
- Handshake:
  - x_ready = !full_x && !flush, derived from state only, never from x_valid.
  - A push occurs on a posedge with x_valid && x_ready.
  - Data stays in FIFO order within each requester. No ordering is guaranteed across requesters; the issuer must not have the same destination outstanding on both paths.
- Arbitration (combinational on FIFO heads, evaluated every cycle):
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant the priority holder, then flip priority to the other requester.
  - A single-requester grant also sets priority to the other requester.
  - Neither non-empty: no grant.
  - The granted head pops at the posedge.
- Output stage (registered, updated every posedge):
  - Grant with head addr != 15: RegWrite<=1, A3<=addr, WD3<=data, PCWrite<=0.
  - Grant with addr == 15: PCWrite<=1, PCData<=data, RegWrite<=0. A3 and WD3 hold their values.
  - No grant: RegWrite<=0 and PCWrite<=0; address and data hold.
  - Strobes are single-cycle pulses, one write per cycle maximum.
- Latency:
  - Push at edge N; earliest pop and output at edge N+1.
  - The register file samples the write at edge N+2.
  - No bypass around an empty FIFO. Sustained throughput is 1 write/cycle total.
- FIFO boundaries:
  - Full: ready=0. A pop in the same cycle does not reopen ready until the next cycle.
  - Push and pop in the same cycle on a non-empty, non-full FIFO: both take effect, count unchanged.
  - Pointers wrap modulo DEPTH.
- pending (combinational):
  - OR over all valid FIFO entries' addresses, plus A3 when RegWrite=1, plus bit 15 when PCWrite=1.
  - A register stays pending through the cycle its strobe is high.
- flush:
  - At the posedge: both FIFOs empty, RegWrite<=0, PCWrite<=0.
  - Pushes are blocked in that cycle (ready=0). Priority is unchanged.
  - flush dominates a simultaneous grant; the granted entry is dropped.

Test Plan:
- Reset release, ALU push {addr=3, data=0x11} at edge 1 -> edge 2: RegWrite=1, A3=3, WD3=0x11 for exactly one cycle; pending[3]=1 from edge 1 until edge 3.
- Both FIFOs loaded with 2 entries each (ALU r1, r2; MEM r4, r5) at the same time -> output order r1, r4, r2, r5 on consecutive cycles; then RegWrite=0.
- MEM push {addr=15, data=0x8000} -> PCWrite=1, PCData=0x8000, RegWrite=0, pending[15]=1 for that cycle.
- Hold alu_valid with no contention: alu_ready stays 1 and 1 write/cycle is sustained. With MEM also streaming, each side gets every other cycle; the ALU FIFO fills (DEPTH=2) and alu_ready drops to 0, then recovers the cycle after a pop.
- Assert flush with 2 queued entries and a staged write -> next cycle RegWrite=0, pending=0, both ready=0 during the flush cycle; a push offered during flush is not accepted.
- Assert Reset low mid-stream, asynchronously between edges -> all outputs 0 immediately; after release, the first grant under contention goes to ALU.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back scheduler for the register file's single write port.
// Two requesters (ALU results, memory loads) each queue into a small FIFO;
// a round-robin arbiter picks one FIFO head per cycle and drives a
// registered write strobe. Writes to R15 are steered to the PC-write
// output instead of the register file. A pending-write scoreboard covers
// every queued or staged destination so decode can stall on RAW hazards.

module regfile_wb_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              push,
    input  logic [3:0]        push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [3:0]        head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [15:0]       occupied
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [3:0]        addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    // Entry storage is pure data: written on push, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and count; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // One-hot OR of destinations held in the live window [rd_ptr, rd_ptr+count).
    always_comb begin
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                occupied[addr_mem[rd_ptr + PTR_W'(i)]] = 1'b1;
            end
        end
    end
endmodule

module regfile_wb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [3:0]        alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [3:0]        mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              RegWrite,
    output logic [3:0]        A3,
    output logic [DATA_W-1:0] WD3,
    output logic              PCWrite,
    output logic [DATA_W-1:0] PCData,
    output logic [15:0]       pending
);
    logic              alu_full, alu_empty, mem_full, mem_empty;
    logic [3:0]        alu_head_addr, mem_head_addr;
    logic [DATA_W-1:0] alu_head_data, mem_head_data;
    logic [15:0]       alu_occ, mem_occ;
    logic              alu_push, mem_push, alu_pop, mem_pop;
    logic              grant_alu, grant_mem;
    logic              prio_mem;

    logic              vld_p0;
    logic [3:0]        addr_p0;
    logic [DATA_W-1:0] data_p0;

    // Ready depends only on occupancy and flush, never on valid.
    assign alu_ready = !alu_full && !flush;
    assign mem_ready = !mem_full && !flush;
    assign alu_push  = alu_valid && alu_ready;
    assign mem_push  = mem_valid && mem_ready;

    regfile_wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_alu_fifo (
        .clk       (clk),
        .Reset     (Reset),
        .flush     (flush),
        .push      (alu_push),
        .push_addr (alu_addr),
        .push_data (alu_data),
        .pop       (alu_pop),
        .full      (alu_full),
        .empty     (alu_empty),
        .head_addr (alu_head_addr),
        .head_data (alu_head_data),
        .occupied  (alu_occ)
    );

    regfile_wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem_fifo (
        .clk       (clk),
        .Reset     (Reset),
        .flush     (flush),
        .push      (mem_push),
        .push_addr (mem_addr),
        .push_data (mem_data),
        .pop       (mem_pop),
        .full      (mem_full),
        .empty     (mem_empty),
        .head_addr (mem_head_addr),
        .head_data (mem_head_data),
        .occupied  (mem_occ)
    );

    // ---- stage p0: round-robin select between FIFO heads ----
    assign grant_alu = !alu_empty && (mem_empty || !prio_mem);
    assign grant_mem = !mem_empty && (alu_empty ||  prio_mem);
    // A flush drops the granted entry, so nothing pops.
    assign alu_pop   = grant_alu && !flush;
    assign mem_pop   = grant_mem && !flush;

    // Mux the winning head onto the p0 write candidate.
    always_comb begin
        vld_p0  = grant_alu || grant_mem;
        addr_p0 = alu_head_addr;
        data_p0 = alu_head_data;
        if (grant_mem) begin
            addr_p0 = mem_head_addr;
            data_p0 = mem_head_data;
        end
    end

    // Priority passes to the other requester after any grant; flush leaves it alone.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            prio_mem <= 1'b0;
        end else if (!flush) begin
            if (grant_alu)      prio_mem <= 1'b1;
            else if (grant_mem) prio_mem <= 1'b0;
        end
    end

    // ---- stage p1: registered write port; R15 goes to the PC instead ----
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            RegWrite <= 1'b0;
            A3       <= '0;
            WD3      <= '0;
            PCWrite  <= 1'b0;
            PCData   <= '0;
        end else if (flush || !vld_p0) begin
            RegWrite <= 1'b0;
            PCWrite  <= 1'b0;
        end else if (addr_p0 == 4'hF) begin
            RegWrite <= 1'b0;
            PCWrite  <= 1'b1;
            PCData   <= data_p0;
        end else begin
            RegWrite <= 1'b1;
            PCWrite  <= 1'b0;
            A3       <= addr_p0;
            WD3      <= data_p0;
        end
    end

    // Scoreboard: queued destinations plus whatever is strobing this cycle.
    always_comb begin
        pending = alu_occ | mem_occ;
        if (RegWrite) pending[A3] = 1'b1;
        if (PCWrite)  pending[15] = 1'b1;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset state, single write latency,
// R15 diversion, round-robin ordering, FIFO full/ready behaviour, flush and
// asynchronous reset mid-stream.

module tb_regfile_wb_arbiter;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              Reset;
    logic              flush;
    logic              alu_valid, alu_ready;
    logic [3:0]        alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid, mem_ready;
    logic [3:0]        mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              RegWrite, PCWrite;
    logic [3:0]        A3;
    logic [DATA_W-1:0] WD3, PCData;
    logic [15:0]       pending;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_wb_arbiter #(.DEPTH(2), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .flush     (flush),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .RegWrite  (RegWrite),
        .A3        (A3),
        .WD3       (WD3),
        .PCWrite   (PCWrite),
        .PCData    (PCData),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0; flush = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        #2;
        check("rst_regwrite", 64'(RegWrite), 64'd0);
        check("rst_pcwrite",  64'(PCWrite),  64'd0);
        check("rst_a3",       64'(A3),       64'd0);
        check("rst_wd3",      64'(WD3),      64'd0);
        check("rst_pcdata",   64'(PCData),   64'd0);
        check("rst_pending",  64'(pending),  64'd0);
        check("rst_alu_ready",64'(alu_ready),64'd1);
        step(); step();
        Reset = 1'b1;

        // Single ALU write to r3
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'h11;
        step();
        alu_valid = 1'b0;
        check("t1_rw_e1",   64'(RegWrite), 64'd0);
        check("t1_pend_e1", 64'(pending),  64'h0008);
        step();
        check("t1_rw_e2",   64'(RegWrite), 64'd1);
        check("t1_a3_e2",   64'(A3),       64'd3);
        check("t1_wd3_e2",  64'(WD3),      64'h11);
        check("t1_pend_e2", 64'(pending),  64'h0008);
        step();
        check("t1_rw_e3",   64'(RegWrite), 64'd0);
        check("t1_pend_e3", 64'(pending),  64'h0000);

        // Load to R15 goes to the PC port; priority returns to ALU afterwards
        mem_valid = 1'b1; mem_addr = 4'd15; mem_data = 32'h8000;
        step();
        mem_valid = 1'b0;
        check("pc_pcw_e1",  64'(PCWrite),  64'd0);
        check("pc_pend_e1", 64'(pending),  64'h8000);
        step();
        check("pc_pcw",     64'(PCWrite),  64'd1);
        check("pc_data",    64'(PCData),   64'h8000);
        check("pc_rw",      64'(RegWrite), 64'd0);
        check("pc_a3_hold", 64'(A3),       64'd3);
        check("pc_wd3_hold",64'(WD3),      64'h11);
        check("pc_pend",    64'(pending),  64'h8000);
        step();
        check("pc_pcw_off", 64'(PCWrite),  64'd0);
        check("pc_pend_off",64'(pending),  64'h0000);

        // Both FIFOs loaded with two entries -> r1, r4, r2, r5
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'h101;
        mem_valid = 1'b1; mem_addr = 4'd4; mem_data = 32'h404;
        step();
        alu_addr = 4'd2; alu_data = 32'h202;
        mem_addr = 4'd5; mem_data = 32'h505;
        check("rr_rw_a",    64'(RegWrite), 64'd0);
        check("rr_pend_a",  64'(pending),  64'h0012);
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        check("rr_rw_1",    64'(RegWrite), 64'd1);
        check("rr_a3_1",    64'(A3),       64'd1);
        check("rr_wd3_1",   64'(WD3),      64'h101);
        check("rr_pend_1",  64'(pending),  64'h0036);
        check("rr_memrdy",  64'(mem_ready),64'd0);
        check("rr_alurdy",  64'(alu_ready),64'd1);
        step();
        check("rr_a3_4",    64'(A3),       64'd4);
        check("rr_wd3_4",   64'(WD3),      64'h404);
        step();
        check("rr_a3_2",    64'(A3),       64'd2);
        check("rr_wd3_2",   64'(WD3),      64'h202);
        step();
        check("rr_a3_5",    64'(A3),       64'd5);
        check("rr_wd3_5",   64'(WD3),      64'h505);
        step();
        check("rr_rw_end",  64'(RegWrite), 64'd0);
        check("rr_pend_end",64'(pending),  64'h0000);

        // ALU streaming alone: one write per cycle, ready stays high
        alu_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            alu_addr = 4'(6 + k); alu_data = 32'(32'h600 + k);
            check("st_ready", 64'(alu_ready), 64'd1);
            step();
            if (k > 0) begin
                check("st_rw", 64'(RegWrite), 64'd1);
                check("st_a3", 64'(A3),       64'(5 + k));
                check("st_wd3",64'(WD3),      64'(32'h5FF + k));
            end
        end
        alu_valid = 1'b0;
        step();
        check("st_a3_last", 64'(A3),       64'd9);
        step();
        check("st_rw_end",  64'(RegWrite), 64'd0);

        // Both streaming: alternation, ALU FIFO fills and recovers
        alu_valid = 1'b1; alu_addr = 4'd10; alu_data = 32'hA0;
        mem_valid = 1'b1; mem_addr = 4'd11; mem_data = 32'hB0;
        step();
        check("ct_rw_1",    64'(RegWrite), 64'd0);
        check("ct_alurdy_1",64'(alu_ready),64'd1);
        step();
        check("ct_a3_2",    64'(A3),       64'd11);
        check("ct_alurdy_2",64'(alu_ready),64'd0);
        check("ct_memrdy_2",64'(mem_ready),64'd1);
        step();
        check("ct_a3_3",    64'(A3),       64'd10);
        check("ct_alurdy_3",64'(alu_ready),64'd1);
        check("ct_memrdy_3",64'(mem_ready),64'd0);
        step();
        check("ct_rw_4",    64'(RegWrite), 64'd1);
        check("ct_a3_4",    64'(A3),       64'd11);
        check("ct_alurdy_4",64'(alu_ready),64'd0);
        check("ct_memrdy_4",64'(mem_ready),64'd1);

        // Flush with queued and staged writes, pushes still offered
        flush = 1'b1;
        #1;
        check("fl_alurdy",  64'(alu_ready),64'd0);
        check("fl_memrdy",  64'(mem_ready),64'd0);
        step();
        flush = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        check("fl_rw",      64'(RegWrite), 64'd0);
        check("fl_pcw",     64'(PCWrite),  64'd0);
        check("fl_pend",    64'(pending),  64'h0000);
        check("fl_alurdy_after", 64'(alu_ready), 64'd1);
        step();
        check("fl_no_push_rw",   64'(RegWrite), 64'd0);
        check("fl_no_push_pend", 64'(pending),  64'h0000);

        // Async reset mid-stream, then priority back to ALU
        alu_valid = 1'b1; alu_addr = 4'd12; alu_data = 32'hC0;
        mem_valid = 1'b1; mem_addr = 4'd13; mem_data = 32'hD0;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        step();
        check("ar_a3_pre",  64'(A3),       64'd12);
        #3;
        Reset = 1'b0;
        #1;
        check("ar_rw",      64'(RegWrite), 64'd0);
        check("ar_a3",      64'(A3),       64'd0);
        check("ar_wd3",     64'(WD3),      64'd0);
        check("ar_pend",    64'(pending),  64'h0000);
        step(); step();
        #2;
        Reset = 1'b1;
        step();
        check("ar_drop_rw",   64'(RegWrite), 64'd0);
        check("ar_drop_pend", 64'(pending),  64'h0000);
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'h1A;
        mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 32'h2B;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        step();
        check("ar_first_a3",  64'(A3),  64'd1);
        check("ar_first_wd3", 64'(WD3), 64'h1A);
        step();
        check("ar_second_a3", 64'(A3),  64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
